// File: rtl/in_service_control.sv
// In-service control for the PIC: runs the two-pulse INTA handshake, owns the ISR,
// EOI/rotation commands and the priority rotation state fed back to the resolver.
module in_service_control #(
  parameter logic [2:0] RESET_ROTATE   = 3'd7,
  parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] interrupt_from_priority_resolver,
  input  logic       inta_n,
  input  logic       auto_eoi,
  input  logic       ocw2_valid,
  input  logic [2:0] ocw2_cmd,
  input  logic [2:0] ocw2_level,
  output logic       int_out,
  output logic [7:0] in_service_register,
  output logic [7:0] highest_level_in_service,
  output logic [2:0] rotate,
  output logic [7:0] clear_interrupt_request,
  output logic [2:0] vector_level,
  output logic       vector_valid,
  output logic       ack_done
);

  typedef enum logic [1:0] {IDLE, WAIT2, ACK2} state_t;

  state_t     state_q, state_d;
  logic       inta_q;
  logic [7:0] isr_q, isr_d;
  logic [2:0] rotate_q, rotate_d;
  logic       aeoi_rot_q, aeoi_rot_d;
  logic [2:0] level_q, level_d;
  logic       spur_q, spur_d;
  logic [7:0] clr_q, clr_d;
  logic [2:0] vlevel_q, vlevel_d;
  logic       vvalid_q, vvalid_d;
  logic       ack_q, ack_d;

  logic       inta_fall, inta_rise;
  logic [7:0] hlis;
  logic [7:0] set_m, aclr, eclr;
  logic       arot, orot;
  logic [2:0] orot_lvl;

  // Lowest set bit wins; the resolver is expected to deliver one-hot anyway.
  function automatic logic [2:0] enc8(input logic [7:0] v);
    logic [2:0] e;
    e = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (v[i]) e = 3'(i);
    return e;
  endfunction

  assign inta_fall = inta_q & ~inta_n;
  assign inta_rise = ~inta_q & inta_n;

  // Scan from rotate+1 (highest) round to rotate (lowest).
  always_comb begin
    logic       found;
    logic [2:0] idx;
    hlis  = '0;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = rotate_q + 3'(k);
      if (!found && isr_q[idx]) begin
        hlis[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    spur_d   = spur_q;
    clr_d    = '0;
    vlevel_d = vlevel_q;
    vvalid_d = vvalid_q;
    ack_d    = 1'b0;
    set_m    = '0;
    aclr     = '0;
    arot     = 1'b0;
    int_out  = 1'b0;
    case (state_q)
      IDLE: begin
        int_out = |interrupt_from_priority_resolver;
        if (inta_fall) begin
          if (|interrupt_from_priority_resolver) begin
            level_d = enc8(interrupt_from_priority_resolver);
            spur_d  = 1'b0;
            set_m   = 8'd1 << enc8(interrupt_from_priority_resolver);
            clr_d   = set_m;
          end else begin
            level_d = SPURIOUS_LEVEL;
            spur_d  = 1'b1;
          end
          state_d = WAIT2;
        end
      end
      WAIT2: begin
        if (inta_fall) begin
          vlevel_d = level_q;
          vvalid_d = 1'b1;
          state_d  = ACK2;
        end
      end
      ACK2: begin
        if (inta_rise) begin
          vvalid_d = 1'b0;
          ack_d    = 1'b1;
          state_d  = IDLE;
          if (auto_eoi && !spur_q) begin
            aclr = 8'd1 << level_q;
            arot = aeoi_rot_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // OCW2 decode; EOI selection uses the pre-update ISR.
  always_comb begin
    eclr       = '0;
    orot       = 1'b0;
    orot_lvl   = rotate_q;
    aeoi_rot_d = aeoi_rot_q;
    if (ocw2_valid) begin
      case (ocw2_cmd)
        3'b001: eclr = hlis;
        3'b011: eclr = 8'd1 << ocw2_level;
        3'b101: begin
          eclr = hlis;
          if (|isr_q) begin
            orot     = 1'b1;
            orot_lvl = enc8(hlis);
          end
        end
        3'b111: begin
          eclr     = 8'd1 << ocw2_level;
          orot     = 1'b1;
          orot_lvl = ocw2_level;
        end
        3'b110: begin
          orot     = 1'b1;
          orot_lvl = ocw2_level;
        end
        3'b100:  aeoi_rot_d = 1'b1;
        3'b000:  aeoi_rot_d = 1'b0;
        default: ;
      endcase
    end
    // Set wins over any clear of the same bit; OCW2 rotation beats AEOI rotation.
    isr_d    = (isr_q & ~eclr & ~aclr) | set_m;
    rotate_d = orot ? orot_lvl : (arot ? level_q : rotate_q);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      inta_q     <= 1'b1;
      isr_q      <= '0;
      rotate_q   <= RESET_ROTATE;
      aeoi_rot_q <= 1'b0;
      level_q    <= '0;
      spur_q     <= 1'b0;
      clr_q      <= '0;
      vlevel_q   <= '0;
      vvalid_q   <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inta_q     <= inta_n;
      isr_q      <= isr_d;
      rotate_q   <= rotate_d;
      aeoi_rot_q <= aeoi_rot_d;
      level_q    <= level_d;
      spur_q     <= spur_d;
      clr_q      <= clr_d;
      vlevel_q   <= vlevel_d;
      vvalid_q   <= vvalid_d;
      ack_q      <= ack_d;
    end
  end

  assign in_service_register      = isr_q;
  assign highest_level_in_service = hlis;
  assign rotate                   = rotate_q;
  assign clear_interrupt_request  = clr_q;
  assign vector_level             = vlevel_q;
  assign vector_valid             = vvalid_q;
  assign ack_done                 = ack_q;

endmodule

// File: tb/tb_in_service_control.sv
// Randomized scoreboard bench for in_service_control against a priority-list model.
module tb_in_service_control;

  logic       clock, reset_n;
  logic [7:0] resolver;
  logic       inta_n, auto_eoi, ocw2_valid;
  logic [2:0] ocw2_cmd, ocw2_level;
  logic       int_out, vector_valid, ack_done;
  logic [7:0] isr, hlis, clr;
  logic [2:0] rotate, vector_level;

  in_service_control dut (
    .clock(clock), .reset_n(reset_n),
    .interrupt_from_priority_resolver(resolver),
    .inta_n(inta_n), .auto_eoi(auto_eoi),
    .ocw2_valid(ocw2_valid), .ocw2_cmd(ocw2_cmd), .ocw2_level(ocw2_level),
    .int_out(int_out), .in_service_register(isr),
    .highest_level_in_service(hlis), .rotate(rotate),
    .clear_interrupt_request(clr), .vector_level(vector_level),
    .vector_valid(vector_valid), .ack_done(ack_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0, bad = 0;

  // Reference state: ISR as a bit set, rotation as the lowest-priority level number.
  logic [7:0] m_isr;
  int         m_rot;
  bit         m_aeoi;

  logic [7:0] clr_q[$];
  logic [7:0] vec_q[$];
  int         ack_q[$];
  bit         prev_vv;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int enc(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Highest in-service level: walk the priority list rot+1, rot+2, ... rot (mod 8).
  function automatic int hi_lvl(input logic [7:0] s, input int rot);
    for (int k = 1; k <= 8; k++) if (s[(rot + k) % 8]) return (rot + k) % 8;
    return -1;
  endfunction

  function automatic logic [7:0] hi_oh(input logic [7:0] s, input int rot);
    int h;
    h = hi_lvl(s, rot);
    return (h < 0) ? 8'h00 : 8'(1 << h);
  endfunction

  task automatic m_step(input logic [7:0] setm, input logic [7:0] aclr, input bit arot,
                        input int alvl, input bit ov, input logic [2:0] cmd, input logic [2:0] lv);
    logic [7:0] pre, clrm;
    int nr, h;
    pre = m_isr; clrm = aclr; nr = m_rot;
    if (arot) nr = alvl;
    if (ov) begin
      h = hi_lvl(pre, m_rot);
      case (cmd)
        3'b001: if (h >= 0) clrm[h] = 1'b1;
        3'b011: clrm[lv] = 1'b1;
        3'b101: if (h >= 0) begin clrm[h] = 1'b1; nr = h; end
        3'b111: begin clrm[lv] = 1'b1; nr = lv; end
        3'b110: nr = lv;
        3'b100: m_aeoi = 1'b1;
        3'b000: m_aeoi = 1'b0;
        default: ;
      endcase
    end
    m_isr = (pre & ~clrm) | setm;
    m_rot = nr;
  endtask

  task automatic step();
    @(posedge clock); #2;
  endtask

  task automatic status_chk(input string tag);
    check({tag, "_isr"}, isr, m_isr);
    check({tag, "_rotate"}, {5'd0, rotate}, 8'(m_rot));
    check({tag, "_hlis"}, hlis, hi_oh(m_isr, m_rot));
  endtask

  task automatic ocw(input logic [2:0] c, input logic [2:0] l);
    ocw2_cmd = c; ocw2_level = l; ocw2_valid = 1'b1;
    m_step(8'h00, 8'h00, 1'b0, 0, 1'b1, c, l);
    step();
    ocw2_valid = 1'b0;
    status_chk("ocw2");
  endtask

  task automatic inta_pair(input logic [7:0] res, input bit drop, input bit ae,
                           input bit co1, input bit co2);
    logic [7:0] eff;
    logic [2:0] c, l;
    int  lvl;
    bit  spur, arot;
    auto_eoi = ae; resolver = res;
    step();
    check("int_out_idle", {7'd0, int_out}, {7'd0, res != 8'h00});
    if (drop) begin resolver = 8'h00; step(); end
    eff  = drop ? 8'h00 : res;
    spur = (eff == 8'h00);
    lvl  = spur ? 7 : enc(eff);
    c = 3'($urandom_range(0, 7)); l = 3'($urandom_range(0, 7));
    if (co1) begin ocw2_cmd = c; ocw2_level = l; ocw2_valid = 1'b1; end
    inta_n = 1'b0;
    if (!spur) clr_q.push_back(8'(1 << lvl));
    m_step(spur ? 8'h00 : 8'(1 << lvl), 8'h00, 1'b0, 0, co1, c, l);
    step();
    ocw2_valid = 1'b0;
    status_chk("fall1");
    check("int_out_wait2", {7'd0, int_out}, 8'h00);
    inta_n = 1'b1; step(); step();
    inta_n = 1'b0; vec_q.push_back(8'(lvl));
    step(); step();
    c = 3'($urandom_range(0, 7)); l = 3'($urandom_range(0, 7));
    if (co2) begin ocw2_cmd = c; ocw2_level = l; ocw2_valid = 1'b1; end
    inta_n = 1'b1; ack_q.push_back(1);
    arot = ae && !spur && m_aeoi;
    m_step(8'h00, (ae && !spur) ? 8'(1 << lvl) : 8'h00, arot, lvl, co2, c, l);
    step();
    ocw2_valid = 1'b0;
    status_chk("rise2");
    resolver = 8'h00;
    step();
  endtask

  // Monitor: pops expectations whenever the DUT presents a pulse or vector.
  initial begin
    logic [7:0] e;
    prev_vv = 1'b0;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (clr != 8'h00) begin
          if (clr_q.size() == 0) check("clr_unexpected", clr, 8'h00);
          else begin e = clr_q.pop_front(); check("clr_pulse", clr, e); end
        end
        if (vector_valid && !prev_vv) begin
          if (vec_q.size() == 0) check("vec_unexpected", {7'd0, vector_valid}, 8'h00);
          else begin e = vec_q.pop_front(); check("vector_level", {5'd0, vector_level}, e); end
        end
        if (ack_done) begin
          if (ack_q.size() == 0) check("ack_unexpected", {7'd0, ack_done}, 8'h00);
          else begin void'(ack_q.pop_front()); check("ack_vv_low", {7'd0, vector_valid}, 8'h00); end
        end
      end
      prev_vv = vector_valid;
    end
  end

  task automatic reset_chk(input string tag);
    check({tag, "_isr"}, isr, 8'h00);
    check({tag, "_rotate"}, {5'd0, rotate}, 8'h07);
    check({tag, "_hlis"}, hlis, 8'h00);
    check({tag, "_clr"}, clr, 8'h00);
    check({tag, "_outs"}, {4'd0, int_out, vector_valid, ack_done, 1'b0}, 8'h00);
    check({tag, "_vlevel"}, {5'd0, vector_level}, 8'h00);
  endtask

  initial begin
    reset_n = 1'b0; resolver = 8'h00; inta_n = 1'b1; auto_eoi = 1'b0;
    ocw2_valid = 1'b0; ocw2_cmd = 3'd0; ocw2_level = 3'd0;
    m_isr = 8'h00; m_rot = 7; m_aeoi = 1'b0;
    step(); step();
    reset_chk("reset");
    reset_n = 1'b1;
    step();

    inta_pair(8'h04, 1'b0, 1'b0, 1'b0, 1'b0);
    check("basic_isr", isr, 8'h04);
    inta_pair(8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    ocw(3'b001, 3'd0);
    check("nseoi_isr", isr, 8'h10);
    check("nseoi_hlis", hlis, 8'h10);
    ocw(3'b011, 3'd4);
    inta_pair(8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    inta_pair(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    ocw(3'b101, 3'd0);
    check("rnseoi_isr", isr, 8'h80);
    check("rnseoi_rot", {5'd0, rotate}, 8'h00);
    check("rnseoi_hlis", hlis, 8'h80);
    ocw(3'b110, 3'd3);
    ocw(3'b011, 3'd7);
    inta_pair(8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    inta_pair(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    check("setpri_hlis", hlis, 8'h10);
    ocw(3'b100, 3'd0);
    inta_pair(8'h20, 1'b0, 1'b1, 1'b0, 1'b0);
    check("aeoi_rot", {5'd0, rotate}, 8'h05);
    check("aeoi_isr", isr, 8'h11);
    inta_pair(8'h40, 1'b1, 1'b0, 1'b0, 1'b0);
    check("spur_isr", isr, 8'h11);

    // Reset while parked in WAIT2.
    resolver = 8'h02; step();
    inta_n = 1'b0; clr_q.push_back(8'h02);
    m_step(8'h02, 8'h00, 1'b0, 0, 1'b0, 3'd0, 3'd0);
    step();
    inta_n = 1'b1; resolver = 8'h00; step(); step();
    #1 reset_n = 1'b0;
    #1 reset_chk("midreset");
    m_isr = 8'h00; m_rot = 7; m_aeoi = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
    inta_pair(8'h08, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post_reset_isr", isr, 8'h08);

    for (int n = 0; n < 150; n++) begin
      logic [7:0] r;
      int pick;
      pick = $urandom_range(0, 8);
      r = (pick == 8) ? 8'h00 : 8'(1 << pick);
      if ($urandom_range(0, 2) == 0)
        ocw(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      else
        inta_pair(r, $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    step(); step();
    check("clr_q_drained", 8'(clr_q.size()), 8'h00);
    check("vec_q_drained", 8'(vec_q.size()), 8'h00);
    check("ack_q_drained", 8'(ack_q.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/in_service_control.md
Name: in_service_control

Overview:
- Sits directly downstream of the PIC priority resolver.
- Consumes its one-hot winning request and runs the two-pulse INTA acknowledge sequence.
- Owns the in-service register (ISR), the EOI/rotation commands and the priority rotation state.
- Feeds `in_service_register`, `highest_level_in_service` and `rotate` back to the resolver, and pulses IRR clears upstream.

Parameters:
- RESET_ROTATE, 3'd7, rotation state after reset. Value = lowest-priority level; 7 means IR0 is highest.
- SPURIOUS_LEVEL, 3'd7, level reported when no request survives at the first INTA.

Ports:
- clock  input  1  system clock; all state on its rising edge
- reset_n  input  1  asynchronous, active-low reset
- interrupt_from_priority_resolver  input  8  one-hot (or zero) winning request
- inta_n  input  1  CPU acknowledge, active low, synchronous to clock
- auto_eoi  input  1  ICW4 AEOI mode
- ocw2_valid  input  1  one-cycle strobe for an OCW2 command
- ocw2_cmd  input  3  {R,SL,EOI}
- ocw2_level  input  3  L2..L0
- int_out  output  1  INT to CPU
- in_service_register  output  8  ISR
- highest_level_in_service  output  8  one-hot highest-priority set ISR bit under current rotation; zero if ISR empty
- rotate  output  3  current lowest-priority level
- clear_interrupt_request  output  8  one-cycle one-hot pulse to IRR
- vector_level  output  3  acknowledged level, valid while vector_valid
- vector_valid  output  1  high from 2nd INTA fall until INTA rise
- ack_done  output  1  one-cycle pulse at end of the 2nd INTA

Behaviour:
- Reset (async assert, sync release): state=IDLE, ISR=0, rotate=RESET_ROTATE, aeoi_rotate=0, all other outputs 0.
- inta_n edges: detected against a registered copy (reset value 1). A fall or rise is acted on the cycle it is seen.
- Priority order: levels ranked starting at rotate+1 (mod 8) as highest, ending at rotate as lowest.

FSM:
- IDLE:
  - int_out = (resolver != 0).
  - On an inta_n fall:
    - If resolver nonzero: latch level = encode(resolver), set ISR[level], pulse clear_interrupt_request[level].
    - Otherwise: level = SPURIOUS_LEVEL, no ISR set, no clear pulse.
  - Go to WAIT2.
- WAIT2:
  - int_out = 0.
  - On the next inta_n fall: vector_level = level, vector_valid = 1, go to ACK2.
- ACK2:
  - On an inta_n rise: vector_valid = 0, pulse ack_done, go to IDLE.
  - If auto_eoi=1 and the acknowledge was not spurious: clear ISR[level] on the same edge.
  - If aeoi_rotate=1 as well: rotate = level on the same edge.
- inta_n rises in IDLE/WAIT2: ignored. A third fall in ACK2: ignored.

OCW2 (acted on the cycle ocw2_valid=1, any state):
- 001 non-specific EOI: clear the highest_level_in_service bit. No-op if ISR=0.
- 011 specific EOI: clear ISR[ocw2_level].
- 101 rotate on non-specific EOI: clear as 001, and rotate = that level. Rotate unchanged if ISR=0.
- 111 rotate on specific EOI: clear ISR[ocw2_level], rotate = ocw2_level.
- 110 set priority: rotate = ocw2_level.
- 100: aeoi_rotate=1. 000: aeoi_rotate=0. 010: no-op.

Arithmetic, outputs and collisions:
- highest_level_in_service: combinational from registered ISR and rotate.
- EOI-selected level: computed from pre-update ISR.
- Set and clear of the same ISR bit in one cycle: set wins.
- AEOI clear and OCW2 EOI in the same cycle: both clears apply.
- rotate conflict in the same cycle: OCW2 wins over AEOI rotate.
- Rotation arithmetic is 3-bit modulo 8.
- clear_interrupt_request: registered, high exactly one cycle.
- Reset mid-sequence: returns immediately to IDLE with ISR=0. A pending acknowledge is abandoned and no ack_done is issued.

Test Plan:
- Reset, resolver=8'h04, two INTA pulses, auto_eoi=0:
  - int_out=1 before the first fall; ISR=8'h04 and clear_interrupt_request=8'h04 for one cycle after it.
  - vector_level=2 with vector_valid=1 during the 2nd pulse; ack_done pulses once on the rise; ISR stays 8'h04.
- ISR=8'h14, rotate=7, OCW2 cmd=001 -> ISR=8'h10, highest_level_in_service=8'h10, rotate=7.
- ISR=8'h81, OCW2 cmd=101, rotate=7 -> ISR=8'h80, rotate=0.
  - highest_level_in_service then reports 8'h80 (IR1 highest, IR7 ranks above IR0).
- OCW2 cmd=110 level=3, then ISR=8'h11 -> rotate=3, highest_level_in_service=8'h10.
- auto_eoi=1 and aeoi_rotate set (cmd=100), resolver=8'h20, INTA pair:
  - ISR bit 5 set at the 1st fall, cleared on the 2nd rise; rotate=5.
- Resolver drops to 0 before the 1st INTA fall:
  - vector_level=7, ISR unchanged, no clear pulse.
- Async reset asserted during WAIT2:
  - all outputs 0 and rotate=7 without a clock edge; the following INTA pair restarts cleanly from IDLE.
